soc_system_sysid_checker: RTL and testbench
===========================================

Name: soc_system_sysid_checker

Overview:
- Avalon-MM master sequencer that reads the system ID peripheral's two words: the ID at address 0 and the timestamp at address 1.
- Compares both against build-time expected values and reports a pass/fail status to the HPS-visible status logic.
- Runs once automatically after reset, and again on each software start pulse.
- Bounds every read with a timeout, so a hung interconnect cannot stall boot.

Parameters:
- EXPECTED_ID, 32'd2899645186, value required at sysid address 0.
- EXPECTED_TS, 32'd1390537961, value required at sysid address 1.
- TIMEOUT_CYCLES, 255, maximum cycles per read transaction (request plus data wait); range 1..65535.
- AUTO_START, 1, when 1 a check launches on the first clock after reset deassertion.

Ports:
- clock  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset; deassertion is synchronous to clock upstream.
- start  input  1  single-cycle pulse that requests a new check; ignored while busy.
- avm_address  output  1  sysid word select (0 = ID, 1 = timestamp).
- avm_read  output  1  read request.
- avm_waitrequest  input  1  interconnect stall; the request is held while it is high.
- avm_readdata  input  32  returned data.
- avm_readdatavalid  input  1  avm_readdata is valid this cycle.
- busy  output  1  check in progress.
- done  output  1  one-cycle pulse at the end of each check.
- id_ok  output  1  ID matched on the last completed check.
- ts_ok  output  1  timestamp matched on the last completed check.
- timeout_err  output  1  last check aborted on timeout.
- id_value  output  32  captured ID word.
- ts_value  output  32  captured timestamp word.

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE; all outputs 0, including avm_read, avm_address, busy, done, flags, id_value, ts_value and the timeout counter. Reset mid-transaction abandons the read. Any late readdatavalid after reset is ignored because the state is IDLE.
- A launch occurs when state is IDLE and either start=1, or AUTO_START=1 and this is the first cycle after reset release (tracked by a one-shot register set at reset).
- On launch:
  - id_ok, ts_ok and timeout_err are cleared.
  - busy goes to 1 the next cycle; state moves to RD_ID_REQ.
- RD_ID_REQ:
  - avm_read=1, avm_address=0.
  - When avm_waitrequest=0 the request is accepted: avm_read drops the next cycle and state moves to RD_ID_WAIT.
  - If readdatavalid arrives in the same cycle as acceptance (zero-latency path), data is captured immediately and state moves to RD_TS_REQ.
- RD_ID_WAIT: on avm_readdatavalid, capture id_value and set id_ok = (avm_readdata == EXPECTED_ID); then go to RD_TS_REQ.
- RD_TS_REQ / RD_TS_WAIT: same as the ID read with avm_address=1. Capture ts_value and ts_ok, then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 the same cycle, then IDLE.
- Timeout:
  - A 16-bit counter clears on entry to each REQ state and increments every cycle in REQ/WAIT.
  - When the count reaches TIMEOUT_CYCLES-1 without completion: avm_read=0, timeout_err=1, the pending ok flag stays 0, and state goes to DONE.
  - A timeout on the ID read skips the timestamp read.
- Flags and captured values hold until the next launch.
- start asserted while busy=1 or in DONE is dropped, not queued.
- readdatavalid outside a WAIT state, or outside the same-cycle acceptance case, is ignored.
- avm_address is stable while avm_read=1. avm_read never deasserts while avm_waitrequest=1 unless a timeout occurs.

Test Plan:
- AUTO_START=1, slave returns 2899645186 and 1390537961 with 2-cycle latency, no waitrequest -> addr 0 then addr 1 read, done pulses once, id_ok=1, ts_ok=1, timeout_err=0, busy low after done.
- Slave returns ID 32'h0 -> id_ok=0, ts_ok=1, id_value=0. Then start pulse with correct data -> id_ok=1; flags clear on launch.
- waitrequest held high for 3 cycles on each read -> avm_read and avm_address stable during the stall, check passes, no timeout.
- TIMEOUT_CYCLES=8, readdatavalid never asserted on the ID read -> timeout_err=1 after 8 cycles, no addr-1 read issued, done pulses, busy=0.
- start pulsed while busy and again in the DONE cycle -> exactly one check performed; a later start in IDLE launches a new check.
- reset_n dropped while in RD_TS_WAIT, then a stray readdatavalid -> all outputs 0 immediately. After release with AUTO_START=1 a fresh check completes correctly.

Source files
------------

// File: rtl/soc_system_sysid_checker.sv
// Boot-time sysid checker: reads the sysid ID and timestamp words over Avalon-MM,
// compares them with build-time values and reports status, bounding each read by a timeout.
module soc_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd2899645186,
  parameter logic [31:0] EXPECTED_TS    = 32'd1390537961,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    StIdle, StIdReq, StIdWait, StTsReq, StTsWait, StDone
  } state_e;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        first_q;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;

  logic in_req, in_wait, ts_phase, accepted, got_data;

  assign in_req   = (state_q == StIdReq) || (state_q == StTsReq);
  assign in_wait  = (state_q == StIdWait) || (state_q == StTsWait);
  assign ts_phase = (state_q == StTsReq) || (state_q == StTsWait);
  assign accepted = in_req && !avm_waitrequest;
  // Data counts in a WAIT state, or in the acceptance cycle itself (zero-latency slave).
  assign got_data = avm_readdatavalid && (accepted || in_wait);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    case (state_q)
      StIdle: begin
        if (start || first_q) begin
          state_d   = StIdReq;
          cnt_d     = '0;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
        end
      end
      StIdReq, StIdWait, StTsReq, StTsWait: begin
        cnt_d = cnt_q + 16'd1;
        if (got_data) begin
          if (ts_phase) begin
            ts_value_d = avm_readdata;
            ts_ok_d    = (avm_readdata == EXPECTED_TS);
            state_d    = StDone;
          end else begin
            id_value_d = avm_readdata;
            id_ok_d    = (avm_readdata == EXPECTED_ID);
            state_d    = StTsReq;
            cnt_d      = '0;
          end
        end else if (accepted) begin
          state_d = ts_phase ? StTsWait : StIdWait;
        end else if (cnt_q >= TimeoutLast) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      first_q    <= AUTO_START;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      first_q    <= 1'b0;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  assign avm_read    = in_req;
  assign avm_address = ts_phase;
  assign busy        = in_req || in_wait;
  assign done        = (state_q == StDone);
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout_err = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Bench for soc_system_sysid_checker: a behavioural Avalon slave with configurable
// stall/latency per word, a vector table, randomized checks and a mid-read reset.
module tb_soc_system_sysid_checker;

  localparam logic [31:0] ExpId = 32'd2899645186;
  localparam logic [31:0] ExpTs = 32'd1390537961;
  localparam int          Tmo   = 8;
  localparam int          Never = 1000;
  localparam int          NumVec = 10;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout_err;
  logic [31:0] id_value;
  logic [31:0] ts_value;
  logic [70:0] outs;

  always #5 clock = ~clock;

  soc_system_sysid_checker #(
    .EXPECTED_ID   (ExpId),
    .EXPECTED_TS   (ExpTs),
    .TIMEOUT_CYCLES(Tmo),
    .AUTO_START    (1'b1)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .start            (start),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy             (busy),
    .done             (done),
    .id_ok            (id_ok),
    .ts_ok            (ts_ok),
    .timeout_err      (timeout_err),
    .id_value         (id_value),
    .ts_value         (ts_value)
  );

  assign outs = {avm_read, avm_address, busy, done, id_ok, ts_ok, timeout_err, id_value, ts_value};

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] cfg_d0, cfg_d1;
  int          cfg_s0, cfg_l0, cfg_s1, cfg_l1;
  bit          pend, pend_addr;
  int          lat_left, stall_cnt;
  logic [31:0] mdl_id, mdl_ts;

  typedef struct {
    bit id_ok;
    bit ts_ok;
    bit to;
    int cyc;
    bit addr1;
  } exp_t;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    int s0;
    int l0;
    int s1;
    int l1;
    bit extra;
    bit id_ok;
    bit ts_ok;
    bit to;
  } vec_t;

  vec_t tbl [NumVec];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // A read of stall s and latency l finishes s+l cycles after its request starts; it
  // succeeds only if that lands within the Tmo-cycle budget (counts 0..Tmo-1).
  function automatic exp_t model(input logic [31:0] d0, input logic [31:0] d1,
                                 input int s0, input int l0, input int s1, input int l1);
    exp_t e;
    bit idc, tsc;
    idc     = (s0 + l0) <= (Tmo - 1);
    tsc     = idc && ((s1 + l1) <= (Tmo - 1));
    e.id_ok = idc && (d0 == ExpId);
    e.ts_ok = tsc && (d1 == ExpTs);
    e.to    = !tsc;
    e.addr1 = idc;
    e.cyc   = 1 + ((idc ? s0 + l0 : Tmo - 1) + 1) + (idc ? ((tsc ? s1 + l1 : Tmo - 1) + 1) : 0);
    return e;
  endfunction

  // Called at each negedge: decides this cycle's slave response from the DUT outputs.
  task automatic slave_step();
    int lat;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = $urandom();
    if (pend) begin
      lat_left--;
      if (lat_left == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = pend_addr ? cfg_d1 : cfg_d0;
        pend              = 1'b0;
      end
    end
    if (avm_read) begin
      if (stall_cnt < (avm_address ? cfg_s1 : cfg_s0)) begin
        avm_waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        stall_cnt = 0;
        lat = avm_address ? cfg_l1 : cfg_l0;
        if (lat == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = avm_address ? cfg_d1 : cfg_d0;
        end else begin
          pend      = 1'b1;
          pend_addr = avm_address;
          lat_left  = lat;
        end
      end
    end
  endtask

  task automatic run_check(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                           input int s0, input int l0, input int s1, input int l1,
                           input bit pulse, input bit extra,
                           input bit e_id, input bit e_ts, input bit e_to);
    exp_t        e;
    int          cyc, done_cnt, done_cyc, post, post_bad, viol;
    bit          addr1, clr_bad, busy_at_done, prev_read, prev_addr, prev_wreq;
    logic [2:0]  flags;
    logic [31:0] id_at, ts_at;
    cyc = 0; done_cnt = 0; done_cyc = -1; post = 0; post_bad = 0; viol = 0;
    addr1 = 0; clr_bad = 0; busy_at_done = 0; prev_read = 0; prev_addr = 0; prev_wreq = 0;
    flags = '0; id_at = '0; ts_at = '0;
    e = model(d0, d1, s0, l0, s1, l1);
    if (e.addr1) mdl_id = d0;
    if (!e.to) mdl_ts = d1;
    cfg_d0 = d0; cfg_d1 = d1; cfg_s0 = s0; cfg_l0 = l0; cfg_s1 = s1; cfg_l1 = l1;
    pend = 1'b0; stall_cnt = 0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    start = pulse;
    while (cyc < 80 && !(done_cnt > 0 && post >= 3)) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1 && (id_ok || ts_ok || timeout_err || !busy)) clr_bad = 1'b1;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc     = cyc;
          busy_at_done = busy;
          flags        = {id_ok, ts_ok, timeout_err};
          id_at        = id_value;
          ts_at        = ts_value;
        end
      end else if (done_cnt > 0) begin
        post++;
        if (busy || avm_read) post_bad++;
      end
      if (avm_read && avm_address) addr1 = 1'b1;
      if (prev_read && prev_wreq) begin
        if (!avm_read && !timeout_err) viol++;
        if (avm_read && (avm_address != prev_addr)) viol++;
      end
      prev_read = avm_read;
      prev_addr = avm_address;
      slave_step();
      prev_wreq = avm_waitrequest;
      start = extra && (cyc == 2 || done);
    end
    start = 1'b0;
    chk({tag, ".launch_clear"}, clr_bad, 0);
    chk({tag, ".done_count"}, done_cnt, 1);
    chk({tag, ".done_cycle"}, done_cyc, e.cyc);
    chk({tag, ".busy_at_done"}, busy_at_done, 0);
    chk({tag, ".flags"}, flags, {e_id, e_ts, e_to});
    chk({tag, ".id_value"}, id_at, mdl_id);
    chk({tag, ".ts_value"}, ts_at, mdl_ts);
    chk({tag, ".addr1_read"}, addr1, e.addr1);
    chk({tag, ".stall_stable"}, viol, 0);
    chk({tag, ".post_idle"}, post_bad, 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    mdl_id = '0; mdl_ts = '0; pend = 1'b0; pend_addr = 1'b0; lat_left = 0; stall_cnt = 0;

    //          d0      d1            s0 l0     s1 l1     x  id ts to
    tbl[0] = '{32'h0,  ExpTs,         0, 2,     0, 2,     0, 0, 1, 0};
    tbl[1] = '{ExpId,  ExpTs,         0, 2,     0, 2,     0, 1, 1, 0};
    tbl[2] = '{ExpId,  ExpTs,         3, 2,     3, 2,     0, 1, 1, 0};
    tbl[3] = '{ExpId,  ExpTs,         0, Never, 0, 2,     0, 0, 0, 1};
    tbl[4] = '{ExpId,  ExpTs,         0, 1,     0, 1,     1, 1, 1, 0};
    tbl[5] = '{ExpId,  ExpTs,         0, 0,     0, 0,     0, 1, 1, 0};
    tbl[6] = '{ExpId,  ExpTs,         5, 2,     7, 0,     0, 1, 1, 0};
    tbl[7] = '{ExpId,  ExpTs,         0, 1,     4, 4,     0, 1, 0, 1};
    tbl[8] = '{ExpId,  ExpTs,         20, 0,    0, 0,     0, 0, 0, 1};
    tbl[9] = '{ExpId,  32'd123,       1, 3,     2, 1,     1, 1, 0, 0};

    repeat (3) @(negedge clock);
    chk("reset_outputs_zero", outs, 0);
    reset_n = 1'b1;
    run_check("auto", ExpId, ExpTs, 0, 2, 0, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < NumVec; i++) begin
      run_check($sformatf("vec%0d", i), tbl[i].d0, tbl[i].d1, tbl[i].s0, tbl[i].l0,
                tbl[i].s1, tbl[i].l1, 1'b1, tbl[i].extra, tbl[i].id_ok, tbl[i].ts_ok, tbl[i].to);
    end

    for (int i = 0; i < 16; i++) begin
      logic [31:0] rd0, rd1;
      int          rs0, rl0, rs1, rl1;
      bit          rx;
      exp_t        re;
      rd0 = ($urandom_range(0, 2) == 0) ? $urandom() : ExpId;
      rd1 = ($urandom_range(0, 2) == 0) ? $urandom() : ExpTs;
      rs0 = int'($urandom_range(0, 4));
      rs1 = int'($urandom_range(0, 4));
      rl0 = ($urandom_range(0, 5) == 0) ? Never : int'($urandom_range(0, 4));
      rl1 = ($urandom_range(0, 5) == 0) ? Never : int'($urandom_range(0, 4));
      rx  = 1'($urandom_range(0, 1));
      re  = model(rd0, rd1, rs0, rl0, rs1, rl1);
      run_check($sformatf("rand%0d", i), rd0, rd1, rs0, rl0, rs1, rl1, 1'b1, rx,
                re.id_ok, re.ts_ok, re.to);
    end

    // Park the DUT in the timestamp data wait, then pull reset underneath it.
    cfg_d0 = ExpId; cfg_d1 = ExpTs; cfg_s0 = 0; cfg_l0 = 1; cfg_s1 = 0; cfg_l1 = Never;
    pend = 1'b0; stall_cnt = 0;
    start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      slave_step();
      start = 1'b0;
    end
    chk("rst.in_ts_wait", {busy, avm_read, avm_address}, 3'b101);
    #2 reset_n = 1'b0;
    #1 chk("rst.async_zero", outs, 0);
    mdl_id = '0; mdl_ts = '0; pend = 1'b0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b1; avm_readdata = ExpId;
    repeat (2) @(negedge clock);
    chk("rst.stray_valid_ignored", outs, 0);
    avm_readdatavalid = 1'b0;
    reset_n = 1'b1;
    run_check("rst.auto", ExpId, ExpTs, 0, 2, 0, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
